// File: rtl/line_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one 64-bit memory port,
// turning each 256-bit line transfer into a BEATS-long burst.
module line_arbiter #(
  parameter int BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [31:0]           i_addr,
  output logic [64*BEATS-1:0]   i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [31:0]           d_addr,
  input  logic [64*BEATS-1:0]   d_wdata,
  output logic [64*BEATS-1:0]   d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [63:0]           mem_wdata,
  input  logic [63:0]           mem_rdata,
  input  logic                  mem_resp
);

  localparam int LW = 64 * BEATS;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_d_q, last_d_d;
  logic            src_d_q, src_d_d;
  logic [31:0]     addr_q, addr_d;
  logic [LW-1:0]   line_q, line_d;

  logic            i_req, d_req, pick_d, last_beat;
  int unsigned     beat_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_d_q <= 1'b0;
      src_d_q  <= 1'b0;
      addr_q   <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_d_q <= last_d_d;
      src_d_q  <= src_d_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    src_d_d   = src_d_q;
    addr_d    = addr_q;
    line_d    = line_q;
    i_req     = i_read;
    d_req     = d_read | d_write;
    // On a tie the client that did not win last time gets the grant.
    pick_d    = d_req & (~i_req | ~last_d_q);
    beat_base = 32'(cnt_q) * 32'd64;
    last_beat = (cnt_q == CW'(BEATS - 1));

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_d_d = pick_d;
          src_d_d  = pick_d;
          addr_d   = pick_d ? {d_addr[31:5], 5'b0} : {i_addr[31:5], 5'b0};
          if (pick_d && d_write) begin
            line_d  = d_wdata;
            state_d = D_WR;
          end else if (pick_d) begin
            state_d = D_RD;
          end else begin
            state_d = I_RD;
          end
        end
      end
      I_RD, D_RD, D_WR: begin
        if (mem_resp) begin
          if (state_q != D_WR) begin
            line_d[beat_base +: 64] = mem_rdata;
          end
          if (last_beat) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side strobes are pure state decodes so read and write cannot overlap.
  assign mem_read  = (state_q == I_RD) || (state_q == D_RD);
  assign mem_write = (state_q == D_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = (state_q == D_WR) ? line_q[beat_base +: 64] : 64'd0;
  assign i_resp    = (state_q == DONE) && !src_d_q;
  assign d_resp    = (state_q == DONE) && src_d_q;
  assign i_rdata   = line_q;
  assign d_rdata   = line_q;

endmodule
